// File: rtl/zeroriscy_ex_issue_pkg.sv
// rtl/zeroriscy_ex_issue_pkg.sv - shared widths, encodings and state type for the issue stage
package zeroriscy_defines;

  localparam int ALU_OP_WIDTH = 6;

  // ALU operation encodings
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 6'h18;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 6'h19;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 6'h2f;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 6'h2e;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 6'h15;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 6'h27;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 6'h25;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 6'h24;

  // Mult/div operation encodings
  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } ex_issue_state_e;

  // Loads write back through the LSU, and x0 is never written.
  function automatic logic rf_write_allowed(input logic we, input logic lsu, input logic [4:0] rd);
    return we & ~lsu & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/zeroriscy_ex_issue_if.sv
// rtl/zeroriscy_ex_issue_if.sv - issue stage to execute block operation/result interface
interface zeroriscy_ex_issue_if;
  import zeroriscy_defines::*;

  logic [ALU_OP_WIDTH-1:0] alu_operator_o;
  logic [1:0]              multdiv_operator_o;
  logic                    mult_en_o;
  logic                    div_en_o;
  logic                    lsu_en_o;
  logic [31:0]             alu_operand_a_o;
  logic [31:0]             alu_operand_b_o;
  logic [31:0]             multdiv_operand_a_o;
  logic [31:0]             multdiv_operand_b_o;
  logic [1:0]              multdiv_signed_mode_o;
  logic                    ex_ready_i;
  logic [31:0]             regfile_wdata_ex_i;

  // Issue stage drives the held operation and waits on the execute block.
  modport master (
    output alu_operator_o, multdiv_operator_o, mult_en_o, div_en_o, lsu_en_o,
    output alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o,
    output multdiv_signed_mode_o,
    input  ex_ready_i, regfile_wdata_ex_i
  );

  modport slave (
    input  alu_operator_o, multdiv_operator_o, mult_en_o, div_en_o, lsu_en_o,
    input  alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o,
    input  multdiv_signed_mode_o,
    output ex_ready_i, regfile_wdata_ex_i
  );

endinterface

// File: rtl/zeroriscy_ex_issue.sv
// rtl/zeroriscy_ex_issue.sv - holds one decoded instruction on the execute block and writes back its result
module zeroriscy_ex_issue
  import zeroriscy_defines::*;
#(
  parameter bit RV32M = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] alu_operator_i,
  input  logic [1:0]              multdiv_operator_i,
  input  logic                    mult_en_i,
  input  logic                    div_en_i,
  input  logic                    lsu_en_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  input  logic [1:0]              signed_mode_i,
  input  logic [4:0]              rd_addr_i,
  input  logic                    rd_we_i,
  input  logic                    flush_i,
  zeroriscy_ex_issue_if.master    ex_if,
  output logic [4:0]              rf_waddr_o,
  output logic [31:0]             rf_wdata_o,
  output logic                    rf_we_o,
  output logic                    busy_o,
  output logic [15:0]             stall_cnt_o
);

  ex_issue_state_e         r_state, w_state_next;
  logic                    w_ready, w_accept, w_retire;

  logic [ALU_OP_WIDTH-1:0] r_alu_operator;
  logic [1:0]              r_multdiv_operator;
  logic                    r_mult_en, r_div_en, r_lsu_en;
  logic [31:0]             r_operand_a, r_operand_b;
  logic [1:0]              r_signed_mode;
  logic [4:0]              r_rd_addr;
  logic                    r_rd_we;
  logic                    r_rf_we;
  logic [4:0]              r_rf_waddr;
  logic [31:0]             r_rf_wdata;
  logic [15:0]             r_stall_cnt;

  // Ready, accept/retire decode and next state; reset and flush block any handshake.
  always_comb begin
    w_ready      = 1'b0;
    w_retire     = 1'b0;
    w_state_next = r_state;
    if (!rst && !flush_i) begin
      case (r_state)
        IDLE: w_ready = 1'b1;
        EXEC: begin
          w_ready  = ex_if.ex_ready_i;
          w_retire = ex_if.ex_ready_i;
        end
        default: w_ready = 1'b0;
      endcase
    end
    w_accept = instr_valid_i & w_ready;
    if (rst || flush_i)   w_state_next = IDLE;
    else if (w_accept)    w_state_next = EXEC;
    else if (w_retire)    w_state_next = IDLE;
  end

  // State, holding register, writeback pulse and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= IDLE;
      r_alu_operator     <= '0;
      r_multdiv_operator <= '0;
      r_mult_en          <= 1'b0;
      r_div_en           <= 1'b0;
      r_lsu_en           <= 1'b0;
      r_operand_a        <= '0;
      r_operand_b        <= '0;
      r_signed_mode      <= '0;
      r_rd_addr          <= '0;
      r_rd_we            <= 1'b0;
      r_rf_we            <= 1'b0;
      r_rf_waddr         <= '0;
      r_rf_wdata         <= '0;
      r_stall_cnt        <= '0;
    end else begin
      r_state <= w_state_next;
      r_rf_we <= w_retire & rf_write_allowed(r_rd_we, r_lsu_en, r_rd_addr);
      if (w_retire) begin
        r_rf_waddr <= r_rd_addr;
        r_rf_wdata <= ex_if.regfile_wdata_ex_i;
      end
      if (r_state == EXEC && !ex_if.ex_ready_i && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (flush_i || (w_retire && !w_accept)) begin
        r_mult_en <= 1'b0;
        r_div_en  <= 1'b0;
        r_lsu_en  <= 1'b0;
        r_rd_we   <= 1'b0;
      end else if (w_accept) begin
        r_alu_operator     <= alu_operator_i;
        r_multdiv_operator <= multdiv_operator_i;
        // div wins when both are requested; without RV32M everything issues as ALU
        r_mult_en          <= RV32M & mult_en_i & ~div_en_i;
        r_div_en           <= RV32M & div_en_i;
        r_lsu_en           <= lsu_en_i;
        r_operand_a        <= operand_a_i;
        r_operand_b        <= operand_b_i;
        r_signed_mode      <= signed_mode_i;
        r_rd_addr          <= rd_addr_i;
        r_rd_we            <= rd_we_i;
      end
    end
  end

  assign instr_ready_o               = w_ready;
  assign busy_o                      = (r_state == EXEC);
  assign stall_cnt_o                 = r_stall_cnt;
  assign rf_we_o                     = r_rf_we;
  assign rf_waddr_o                  = r_rf_waddr;
  assign rf_wdata_o                  = r_rf_wdata;
  assign ex_if.alu_operator_o        = r_alu_operator;
  assign ex_if.multdiv_operator_o    = r_multdiv_operator;
  assign ex_if.mult_en_o             = r_mult_en;
  assign ex_if.div_en_o              = r_div_en;
  assign ex_if.lsu_en_o              = r_lsu_en;
  assign ex_if.alu_operand_a_o       = r_operand_a;
  assign ex_if.alu_operand_b_o       = r_operand_b;
  assign ex_if.multdiv_operand_a_o   = r_operand_a;
  assign ex_if.multdiv_operand_b_o   = r_operand_b;
  assign ex_if.multdiv_signed_mode_o = r_signed_mode;

endmodule

// File: tb/tb_zeroriscy_ex_issue.sv
// tb/tb_zeroriscy_ex_issue.sv - self-checking bench for zeroriscy_ex_issue (RV32M=1 and RV32M=0)
module tb_zeroriscy_ex_issue;
  import zeroriscy_defines::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, instr_valid, mult_en, div_en, lsu_en, rd_we, flush, ex_ready;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [1:0]              md_op, sm;
  logic [31:0]             op_a, op_b, wdata_ex;
  logic [4:0]              rd_addr;

  logic                    rdy[2], rf_we[2], busy[2];
  logic [4:0]              rf_waddr[2];
  logic [31:0]             rf_wdata[2];
  logic [15:0]             stall[2];

  logic [ALU_OP_WIDTH-1:0] o_alu[2];
  logic [1:0]              o_mdop[2], o_sm[2];
  logic                    o_mult[2], o_div[2], o_lsu[2];
  logic [31:0]             o_aa[2], o_ab[2], o_ma[2], o_mb[2];

  zeroriscy_ex_issue_if exif0();
  zeroriscy_ex_issue_if exif1();
  assign exif0.ex_ready_i = ex_ready;
  assign exif1.ex_ready_i = ex_ready;
  assign exif0.regfile_wdata_ex_i = wdata_ex;
  assign exif1.regfile_wdata_ex_i = wdata_ex;

  assign o_alu[0] = exif0.alu_operator_o;        assign o_alu[1] = exif1.alu_operator_o;
  assign o_mdop[0] = exif0.multdiv_operator_o;   assign o_mdop[1] = exif1.multdiv_operator_o;
  assign o_sm[0] = exif0.multdiv_signed_mode_o;  assign o_sm[1] = exif1.multdiv_signed_mode_o;
  assign o_mult[0] = exif0.mult_en_o;            assign o_mult[1] = exif1.mult_en_o;
  assign o_div[0] = exif0.div_en_o;              assign o_div[1] = exif1.div_en_o;
  assign o_lsu[0] = exif0.lsu_en_o;              assign o_lsu[1] = exif1.lsu_en_o;
  assign o_aa[0] = exif0.alu_operand_a_o;        assign o_aa[1] = exif1.alu_operand_a_o;
  assign o_ab[0] = exif0.alu_operand_b_o;        assign o_ab[1] = exif1.alu_operand_b_o;
  assign o_ma[0] = exif0.multdiv_operand_a_o;    assign o_ma[1] = exif1.multdiv_operand_a_o;
  assign o_mb[0] = exif0.multdiv_operand_b_o;    assign o_mb[1] = exif1.multdiv_operand_b_o;

  zeroriscy_ex_issue #(.RV32M(1'b1)) dut_m (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid), .instr_ready_o(rdy[0]),
    .alu_operator_i(alu_op), .multdiv_operator_i(md_op), .mult_en_i(mult_en), .div_en_i(div_en),
    .lsu_en_i(lsu_en), .operand_a_i(op_a), .operand_b_i(op_b), .signed_mode_i(sm),
    .rd_addr_i(rd_addr), .rd_we_i(rd_we), .flush_i(flush), .ex_if(exif0),
    .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]), .rf_we_o(rf_we[0]),
    .busy_o(busy[0]), .stall_cnt_o(stall[0]));

  zeroriscy_ex_issue #(.RV32M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid), .instr_ready_o(rdy[1]),
    .alu_operator_i(alu_op), .multdiv_operator_i(md_op), .mult_en_i(mult_en), .div_en_i(div_en),
    .lsu_en_i(lsu_en), .operand_a_i(op_a), .operand_b_i(op_b), .signed_mode_i(sm),
    .rd_addr_i(rd_addr), .rd_we_i(rd_we), .flush_i(flush), .ex_if(exif1),
    .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]), .rf_we_o(rf_we[1]),
    .busy_o(busy[1]), .stall_cnt_o(stall[1]));

  int n_checks = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] t=%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // Reference: an instruction is either in flight or not; what it drives is what was accepted.
  typedef struct {
    bit          held;
    logic [5:0]  alu_op;
    logic [1:0]  md_op, sm;
    bit          mult, div, lsu, we;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          wr_pulse;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    int          stalls;
  } model_t;
  model_t m[2];

  function automatic bit can_take(int k);
    return !rst && !flush && (!m[k].held || ex_ready);
  endfunction

  always @(posedge clk) begin
    bit completes, takes;
    for (int k = 0; k < 2; k++) begin
      takes = instr_valid && can_take(k);
      if (rst) begin
        m[k] = '{default: 0};
      end else begin
        completes = m[k].held && ex_ready && !flush;
        m[k].wr_pulse = completes && m[k].we && !m[k].lsu && (m[k].rd != 5'd0);
        if (completes) begin
          m[k].wr_addr = m[k].rd;
          m[k].wr_data = wdata_ex;
        end
        if (m[k].held && !ex_ready && m[k].stalls < 65535) m[k].stalls++;
        if (takes) begin
          m[k].held   = 1'b1;
          m[k].alu_op = alu_op;
          m[k].md_op  = md_op;
          m[k].sm     = sm;
          m[k].div    = (k == 0) && div_en;
          m[k].mult   = (k == 0) && mult_en && !div_en;
          m[k].lsu    = lsu_en;
          m[k].we     = rd_we;
          m[k].a      = op_a;
          m[k].b      = op_b;
          m[k].rd     = rd_addr;
        end else if (completes || flush) begin
          m[k].held = 1'b0;
          m[k].mult = 1'b0;
          m[k].div  = 1'b0;
          m[k].lsu  = 1'b0;
          m[k].we   = 1'b0;
        end
      end
    end
  end

  // Registered outputs checked mid-cycle, the combinational ready after inputs settle.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, busy[k], m[k].held);
        chk("stall_cnt", k, stall[k], m[k].stalls);
        chk("rf_we", k, rf_we[k], m[k].wr_pulse);
        chk("rf_waddr", k, rf_waddr[k], m[k].wr_addr);
        chk("rf_wdata", k, rf_wdata[k], m[k].wr_data);
        chk("mult_en", k, o_mult[k], m[k].mult);
        chk("div_en", k, o_div[k], m[k].div);
        chk("lsu_en", k, o_lsu[k], m[k].lsu);
        chk("alu_operator", k, o_alu[k], m[k].alu_op);
        chk("multdiv_operator", k, o_mdop[k], m[k].md_op);
        chk("signed_mode", k, o_sm[k], m[k].sm);
        chk("alu_operand_a", k, o_aa[k], m[k].a);
        chk("alu_operand_b", k, o_ab[k], m[k].b);
        chk("multdiv_operand_a", k, o_ma[k], m[k].a);
        chk("multdiv_operand_b", k, o_mb[k], m[k].b);
      end
      #2;
      for (int k = 0; k < 2; k++) chk("instr_ready", k, rdy[k], can_take(k));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet();
    instr_valid = 0; flush = 0; mult_en = 0; div_en = 0; lsu_en = 0; rd_we = 0; ex_ready = 0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we);
    instr_valid = 1; alu_op = op; op_a = a; op_b = b; rd_addr = rd; rd_we = we;
  endtask

  int pulses;

  initial begin
    rst = 1; quiet(); alu_op = '0; md_op = '0; sm = '0; op_a = '0; op_b = '0; rd_addr = '0; wdata_ex = '0;
    step(); step();
    // reset values, ready low while rst is high
    for (int k = 0; k < 2; k++) begin
      chk("lit_reset_busy", k, busy[k], 0);
      chk("lit_reset_rf_we", k, rf_we[k], 0);
      chk("lit_reset_stall", k, stall[k], 0);
      chk("lit_reset_operand", k, o_aa[k], 0);
      chk("lit_reset_ready", k, rdy[k], 0);
    end
    cmp_on = 1'b1;
    rst = 0;

    // DIV held through 34 stall cycles
    issue(ALU_ADD, 32'd100, 32'd7, 5'd4, 1'b1); div_en = 1; md_op = MD_OP_DIV;
    step();
    instr_valid = 0; div_en = 0;
    chk("lit_div_en", 0, o_div[0], 1);
    pulses = 0;
    for (int i = 0; i < 34; i++) begin
      step();
      chk("lit_div_hold_a", 0, o_ma[0], 32'd100);
      chk("lit_div_hold_b", 0, o_mb[0], 32'd7);
      #1 chk("lit_div_ready", 0, rdy[0], 0);
      pulses += int'(rf_we[0]);
    end
    ex_ready = 1; wdata_ex = 32'h10;
    step();
    pulses += int'(rf_we[0]);
    chk("lit_div_wdata", 0, rf_wdata[0], 32'h10);
    chk("lit_div_stall", 0, stall[0], 34);
    chk("lit_div_stall", 1, stall[1], 34);
    ex_ready = 0;
    step();
    pulses += int'(rf_we[0]);
    chk("lit_div_pulses", 0, pulses, 1);
    chk("lit_div_idle", 0, busy[0], 0);

    // back-to-back ADD
    ex_ready = 1; issue(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
    step();
    chk("lit_add1_a", 0, o_aa[0], 32'd5);
    op_a = 32'd1; op_b = 32'd2; wdata_ex = 32'd12;
    #1 chk("lit_add_ready", 0, rdy[0], 1);
    step();
    chk("lit_add1_we", 0, rf_we[0], 1);
    chk("lit_add1_wdata", 0, rf_wdata[0], 32'd12);
    chk("lit_add1_waddr", 0, rf_waddr[0], 32'd3);
    chk("lit_add2_a", 0, o_aa[0], 32'd1);
    instr_valid = 0; wdata_ex = 32'd3;
    #1 chk("lit_add_ready2", 0, rdy[0], 1);
    step();
    chk("lit_add2_we", 0, rf_we[0], 1);
    chk("lit_add2_wdata", 0, rf_wdata[0], 32'd3);
    step();
    chk("lit_add_done", 0, rf_we[0], 0);

    // flush in cycle 10 of a DIV with ex_ready high
    ex_ready = 0; issue(ALU_ADD, 32'd9, 32'd3, 5'd6, 1'b1); div_en = 1;
    step();
    instr_valid = 0; div_en = 0;
    for (int i = 0; i < 9; i++) step();
    flush = 1; ex_ready = 1; wdata_ex = 32'hDEAD;
    #1 chk("lit_flush_ready", 0, rdy[0], 0);
    step();
    chk("lit_flush_we", 0, rf_we[0], 0);
    chk("lit_flush_div", 0, o_div[0], 0);
    chk("lit_flush_busy", 0, busy[0], 0);
    flush = 0; ex_ready = 0;
    step();
    chk("lit_flush_we2", 0, rf_we[0], 0);

    // x0 destination and LSU op never pulse
    ex_ready = 1; issue(ALU_ADD, 32'd1, 32'd1, 5'd0, 1'b1); wdata_ex = 32'h77;
    step();
    rd_addr = 5'd5; lsu_en = 1;
    step();
    chk("lit_x0_we", 0, rf_we[0], 0);
    instr_valid = 0; lsu_en = 0;
    step();
    chk("lit_lsu_we", 0, rf_we[0], 0);

    // mult without RV32M issues as ALU; both enables high gives div
    issue(ALU_ADD, 32'd6, 32'd7, 5'd7, 1'b1); mult_en = 1; md_op = MD_OP_MULL; wdata_ex = 32'h55;
    step();
    chk("lit_nom_mult", 1, o_mult[1], 0);
    chk("lit_m_mult", 0, o_mult[0], 1);
    div_en = 1;
    step();
    chk("lit_nom_we", 1, rf_we[1], 1);
    chk("lit_nom_wdata", 1, rf_wdata[1], 32'h55);
    chk("lit_both_div", 0, o_div[0], 1);
    chk("lit_both_mult", 0, o_mult[0], 0);
    quiet();
    step(); step();

    // reset during a MUL stall
    rst = 1; step(); rst = 0;
    issue(ALU_ADD, 32'd3, 32'd4, 5'd8, 1'b1); mult_en = 1;
    step();
    instr_valid = 0; mult_en = 0;
    for (int i = 0; i < 7; i++) step();
    chk("lit_mul_stall", 0, stall[0], 7);
    rst = 1; ex_ready = 1; wdata_ex = 32'hBEEF;
    #1 chk("lit_rst_ready", 0, rdy[0], 0);
    step();
    chk("lit_rst_we", 0, rf_we[0], 0);
    chk("lit_rst_stall", 0, stall[0], 0);
    chk("lit_rst_mult", 0, o_mult[0], 0);
    chk("lit_rst_busy", 0, busy[0], 0);
    chk("lit_rst_wdata", 0, rf_wdata[0], 0);
    rst = 0; ex_ready = 0;
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      instr_valid = ($urandom_range(0, 9) < 6);
      ex_ready    = ($urandom_range(0, 9) < 5);
      alu_op      = 6'($urandom);
      md_op       = 2'($urandom);
      sm          = 2'($urandom);
      mult_en     = 1'($urandom);
      div_en      = 1'($urandom);
      lsu_en      = ($urandom_range(0, 3) == 0);
      rd_we       = 1'($urandom);
      rd_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      op_a        = $urandom;
      op_b        = $urandom;
      wdata_ex    = $urandom;
      step();
    end
    quiet(); rst = 0;
    step(); step();
    cmp_on = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/zeroriscy_ex_issue.md
# zeroriscy_ex_issue

Issue stage between the decoder and the execute block. It accepts one decoded instruction at a time over a valid/ready handshake and holds its operation and operands stable on the execute-block inputs until the execute block signals ready. It then captures the execute result and emits a registered one-cycle register-file write. It is the initiator end of the execute-block interface.

## Interface
Parameters:
- RV32M, 1, enables mult/div issue; when 0, mult/div enables are forced low.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous and active-high
- instr_valid_i  in  1  decoder has an instruction
- instr_ready_o  out  1  instruction accepted this cycle if valid
- alu_operator_i  in  ALU_OP_WIDTH  ALU operation
- multdiv_operator_i  in  2  mult/div operation
- mult_en_i / div_en_i / lsu_en_i  in  1 each  unit selects
- operand_a_i / operand_b_i  in  32 each  source operands, used for both ALU and mult/div
- signed_mode_i  in  2  mult/div signedness
- rd_addr_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- flush_i  in  1  kill the held instruction
- alu_operator_o, multdiv_operator_o, mult_en_o, div_en_o, lsu_en_o, alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o, multdiv_signed_mode_o  out  widths as the inputs  held operation to the execute block
- ex_ready_i  in  1  execute block done with the held operation
- regfile_wdata_ex_i  in  32  execute result
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- rf_we_o  out  1  one-cycle write pulse
- busy_o  out  1  an instruction is held
- stall_cnt_o  out  16  saturating count of EXEC cycles with ex_ready_i low

## Operation
- FSM states: IDLE and EXEC.
- IDLE:
  - instr_ready_o = 1.
  - On instr_valid_i: register every field, go to EXEC.
- EXEC:
  - All held outputs stay constant.
  - instr_ready_o = ex_ready_i.
  - On ex_ready_i: capture regfile_wdata_ex_i and rd_addr into rf_wdata_o / rf_waddr_o.
  - rf_we_o pulses next cycle iff held rd_we & ~lsu_en & rd_addr != 0. Load writeback belongs to the LSU.
  - If ex_ready_i and instr_valid_i: load the new instruction, stay in EXEC (back-to-back issue).
  - If ex_ready_i and no valid: go to IDLE and clear all enables to 0.
- flush_i has highest priority:
  - instr_ready_o = 0 and no accept.
  - No rf_we_o pulse, even if ex_ready_i is high the same cycle.
  - Enables cleared next cycle, state goes to IDLE.
- RV32M=0: mult_en_o = div_en_o = 0; the op issues as an ALU op.
- Mult and div enables are never both set. If both inputs are high, div wins.
- stall_cnt_o:
  - Increments each EXEC cycle with ex_ready_i = 0.
  - Saturates at 0xFFFF.
  - Cleared only by rst.
- busy_o = (state == EXEC).

## Timing
- Accept in cycle N → operation on execute inputs in cycle N+1.
- Single-cycle op: rf_we_o in cycle N+2. Throughput is 1 instruction/cycle.
- Multi-cycle op: rf_we_o one cycle after the cycle in which ex_ready_i = 1.
- instr_ready_o is combinational from state, ex_ready_i and flush_i. All other outputs are registered.
- Reset state, in the cycle after rst is sampled high:
  - state IDLE.
  - All enables, operators, operands, signed_mode = 0.
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
  - stall_cnt_o = 0, busy_o = 0.
  - instr_ready_o = 0 while rst is high.
- Reset mid-operation drops the held op. No write pulse is generated.

## Structure
- zeroriscy_defines package holds:
  - ALU_OP_WIDTH and ALU op encodings.
  - Mult/div operator encodings.
  - New typedef ex_issue_state_e {IDLE, EXEC}.
- Single module, no sub-module. The holding register and FSM are one always_ff; the ready logic is one always_comb.

## Test plan
- Back-to-back ADD: a=5,b=7 then a=1,b=2 in consecutive cycles, ex_ready_i=1, ex returns 12 then 3 → rf_we_o in cycles N+2 and N+3 with wdata 12 and 3; instr_ready_o stays 1.
- DIV stall: div_en_i with ex_ready_i low for 34 cycles, then high with result 0x10 → operands constant throughout, instr_ready_o=0, stall_cnt_o=34, exactly one rf_we_o with wdata 0x10.
- flush_i in cycle 10 of a DIV, ex_ready_i=1 in the same cycle → no rf_we_o, div_en_o=0 next cycle, busy_o=0.
- rd_addr_i=0 with rd_we_i=1, and an lsu_en_i op with rd=5 → no rf_we_o in either case.
- RV32M=0 with mult_en_i=1 → mult_en_o=0, ALU result written.
- rst asserted during a MUL stall with stall_cnt_o=7 → next cycle all outputs 0, stall_cnt_o=0, no write.
